lpif_txrx_asym_gearbox: RTL and testbench

- Parametrised successor to the fixed x4 LPIF lane packer.
- Packs or unpacks NUM_CH LPIF lanes to or from the logic-link FIFO word, with registered timing and valid/ready handshaking on TX.
- Two modes:
  - Gen2 (full ratio): one lane-group per beat.
  - Gen1 (half ratio): one LPIF beat is carried over two link beats using only the lower NUM_CH/2 lanes.
- Sits between the LPIF adapter and the LLINK TX/RX FIFOs.

---
 rtl/lpif_txrx_asym_gearbox.sv | 230 +++++++++++++++++++++++
 tb/tb_lpif_txrx_asym_gearbox.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpif_txrx_asym_gearbox.sv
// lpif_txrx_asym_gearbox
// Packs NUM_CH LPIF lanes into the LLINK TX FIFO word and unpacks the RX FIFO
// word back into lanes. Gen2 moves a whole lane group per link beat. Gen1
// carries one LPIF beat over two link beats using only the lower NUM_CH/2
// link slots.
// Optional feature macro: LPIF_TXRX_BEAT_CNT_EN adds saturating beat counters.
module lpif_txrx_asym_gearbox #(
  parameter int NUM_CH   = 4,
  parameter int STATE_W  = 4,
  parameter int PROTID_W = 2,
  parameter int DATA_W   = 64,
  parameter int CRC_W    = 4
) (
  input  logic                       clk_wr,
  input  logic                       rst_wr_n,
  input  logic                       m_gen2_mode,
  input  logic [NUM_CH*STATE_W-1:0]  dstrm_state,
  input  logic [NUM_CH*PROTID_W-1:0] dstrm_protid,
  input  logic [NUM_CH*DATA_W-1:0]   dstrm_data,
  input  logic [NUM_CH-1:0]          dstrm_dvalid,
  input  logic [NUM_CH*CRC_W-1:0]    dstrm_crc,
  input  logic [NUM_CH-1:0]          dstrm_crc_valid,
  input  logic [NUM_CH-1:0]          dstrm_valid,
  input  logic                       dstrm_beat_vld,
  output logic                       dstrm_beat_rdy,
  output logic [NUM_CH*(STATE_W+PROTID_W+DATA_W+CRC_W+3)-1:0] txfifo_downstream_data,
  output logic                       txfifo_vld,
  input  logic                       txfifo_rdy,
  input  logic [NUM_CH*(STATE_W+PROTID_W+DATA_W+CRC_W+3)-1:0] rxfifo_upstream_data,
  input  logic                       rxfifo_vld,
  output logic [NUM_CH*STATE_W-1:0]  ustrm_state,
  output logic [NUM_CH*PROTID_W-1:0] ustrm_protid,
  output logic [NUM_CH*DATA_W-1:0]   ustrm_data,
  output logic [NUM_CH-1:0]          ustrm_dvalid,
  output logic [NUM_CH*CRC_W-1:0]    ustrm_crc,
  output logic [NUM_CH-1:0]          ustrm_crc_valid,
  output logic [NUM_CH-1:0]          ustrm_valid,
  output logic                       ustrm_beat_vld
`ifdef LPIF_TXRX_BEAT_CNT_EN
  ,
  output logic [31:0]                tx_beat_cnt,
  output logic [31:0]                rx_beat_cnt
`endif
);

  // Per-lane layout, LSB first: state, protid, data, dvalid, crc, crc_valid, valid
  localparam int LANE_W     = STATE_W + PROTID_W + DATA_W + CRC_W + 3;
  localparam int WORD_W     = NUM_CH * LANE_W;
  localparam int HALF_W     = WORD_W / 2;
  localparam int OFF_PROTID = STATE_W;
  localparam int OFF_DATA   = OFF_PROTID + PROTID_W;
  localparam int OFF_DVALID = OFF_DATA + DATA_W;
  localparam int OFF_CRC    = OFF_DVALID + 1;
  localparam int OFF_CRCV   = OFF_CRC + CRC_W;
  localparam int OFF_VALID  = OFF_CRCV + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FULL    = 2'd1,
    ST_HALF_LO = 2'd2,
    ST_HALF_HI = 2'd3
  } tx_state_t;

  tx_state_t           state_reg, state_next;
  logic [WORD_W-1:0]   tx_word_reg;
  logic [HALF_W-1:0]   tx_hi_reg;
  logic                tx_vld_reg;
  logic                mode_q_reg;
  logic                rx_phase_reg;
  logic [HALF_W-1:0]   rx_lo_reg;
  logic [WORD_W-1:0]   rx_word_reg;
  logic                rx_pulse_reg;

  logic                rdy_int;
  logic                load_beat;
  logic                send_hi;
  logic                drop_vld;
  logic                rx_fire;
  logic [WORD_W-1:0]   tx_pack;

  // Lane packing of the downstream beat and unpacking of the held upstream word
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    assign tx_pack[gi*LANE_W +: LANE_W] = {
      dstrm_valid[gi],
      dstrm_crc_valid[gi],
      dstrm_crc[gi*CRC_W +: CRC_W],
      dstrm_dvalid[gi],
      dstrm_data[gi*DATA_W +: DATA_W],
      dstrm_protid[gi*PROTID_W +: PROTID_W],
      dstrm_state[gi*STATE_W +: STATE_W]
    };

    assign ustrm_state[gi*STATE_W +: STATE_W]    = rx_word_reg[gi*LANE_W +: STATE_W];
    assign ustrm_protid[gi*PROTID_W +: PROTID_W] = rx_word_reg[gi*LANE_W + OFF_PROTID +: PROTID_W];
    assign ustrm_data[gi*DATA_W +: DATA_W]       = rx_word_reg[gi*LANE_W + OFF_DATA +: DATA_W];
    assign ustrm_dvalid[gi]                      = rx_word_reg[gi*LANE_W + OFF_DVALID];
    assign ustrm_crc[gi*CRC_W +: CRC_W]          = rx_word_reg[gi*LANE_W + OFF_CRC +: CRC_W];
    assign ustrm_crc_valid[gi]                   = rx_word_reg[gi*LANE_W + OFF_CRCV];
    assign ustrm_valid[gi]                       = rx_word_reg[gi*LANE_W + OFF_VALID];
  end

  // Ready is forced low while reset is held so nothing is accepted during reset
  assign dstrm_beat_rdy         = rdy_int & rst_wr_n;
  assign txfifo_downstream_data = tx_word_reg;
  assign txfifo_vld             = tx_vld_reg;
  assign ustrm_beat_vld         = rx_pulse_reg;
  assign rx_fire                = rxfifo_vld & (mode_q_reg | rx_phase_reg);

  // TX state register
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // TX next-state and handshake decode
  always_comb begin
    state_next = state_reg;
    rdy_int    = 1'b0;
    load_beat  = 1'b0;
    send_hi    = 1'b0;
    drop_vld   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        rdy_int   = 1'b1;
        load_beat = dstrm_beat_vld;
      end
      ST_FULL, ST_HALF_HI: begin
        if (txfifo_rdy) begin
          rdy_int = 1'b1;
          if (dstrm_beat_vld) begin
            load_beat = 1'b1;
          end else begin
            drop_vld   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_HALF_LO: begin
        if (txfifo_rdy) begin
          send_hi    = 1'b1;
          state_next = ST_HALF_HI;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (load_beat) begin
      state_next = mode_q_reg ? ST_FULL : ST_HALF_LO;
    end
  end

  // TX output register: a Gen1 beat keeps its upper lanes aside for the second link beat
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      tx_word_reg <= '0;
      tx_hi_reg   <= '0;
      tx_vld_reg  <= 1'b0;
    end else if (load_beat) begin
      tx_vld_reg <= 1'b1;
      tx_hi_reg  <= tx_pack[WORD_W-1 -: HALF_W];
      if (mode_q_reg) begin
        tx_word_reg <= tx_pack;
      end else begin
        tx_word_reg <= {{(WORD_W-HALF_W){1'b0}}, tx_pack[HALF_W-1:0]};
      end
    end else if (send_hi) begin
      tx_word_reg <= {{(WORD_W-HALF_W){1'b0}}, tx_hi_reg};
    end else if (drop_vld) begin
      tx_vld_reg <= 1'b0;
    end
  end

  // Mode copy only moves when neither direction is part-way through a beat
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      mode_q_reg <= 1'b1;
    end else if ((state_reg == ST_IDLE) && !tx_vld_reg && !rx_phase_reg) begin
      mode_q_reg <= m_gen2_mode;
    end
  end

  // RX unpack: Gen1 stores the first half and completes on the second valid word
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      rx_phase_reg <= 1'b0;
      rx_lo_reg    <= '0;
      rx_word_reg  <= '0;
      rx_pulse_reg <= 1'b0;
    end else begin
      rx_pulse_reg <= rx_fire;
      if (rxfifo_vld) begin
        if (mode_q_reg) begin
          rx_word_reg <= rxfifo_upstream_data;
        end else if (!rx_phase_reg) begin
          rx_lo_reg    <= rxfifo_upstream_data[HALF_W-1:0];
          rx_phase_reg <= 1'b1;
        end else begin
          rx_word_reg  <= {rxfifo_upstream_data[HALF_W-1:0], rx_lo_reg};
          rx_phase_reg <= 1'b0;
        end
      end
    end
  end

`ifdef LPIF_TXRX_BEAT_CNT_EN
  logic [31:0] tx_cnt_reg;
  logic [31:0] rx_cnt_reg;

  assign tx_beat_cnt = tx_cnt_reg;
  assign rx_beat_cnt = rx_cnt_reg;

  // Saturating counts of accepted downstream beats and delivered upstream beats
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      tx_cnt_reg <= '0;
      rx_cnt_reg <= '0;
    end else begin
      if (load_beat && (tx_cnt_reg != 32'hFFFF_FFFF)) begin
        tx_cnt_reg <= tx_cnt_reg + 32'd1;
      end
      if (rx_fire && (rx_cnt_reg != 32'hFFFF_FFFF)) begin
        rx_cnt_reg <= rx_cnt_reg + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lpif_txrx_asym_gearbox.sv
// Self-checking bench for lpif_txrx_asym_gearbox: a table of single-beat
// vectors, directed corner sequences and randomized traffic, all compared
// against a queue-based model of the link word stream.
module tb_lpif_txrx_asym_gearbox;
  localparam int NC = 4;
  localparam int SW = 4;
  localparam int PW = 2;
  localparam int DW = 64;
  localparam int CW = 4;
  localparam int LW = SW + PW + DW + CW + 3;
  localparam int WW = NC * LW;
  localparam int HW = WW / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             gen2 = 1'b1;
  logic [NC*SW-1:0] d_state = '0;
  logic [NC*PW-1:0] d_protid = '0;
  logic [NC*DW-1:0] d_data = '0;
  logic [NC-1:0]    d_dvalid = '0;
  logic [NC*CW-1:0] d_crc = '0;
  logic [NC-1:0]    d_crcv = '0;
  logic [NC-1:0]    d_valid = '0;
  logic             d_beat_vld = 1'b0;
  logic             dstrm_beat_rdy;
  logic [WW-1:0]    tx_data;
  logic             tx_vld;
  logic             tx_rdy = 1'b1;
  logic [WW-1:0]    rx_data = '0;
  logic             rx_vld = 1'b0;
  logic [NC*SW-1:0] u_state;
  logic [NC*PW-1:0] u_protid;
  logic [NC*DW-1:0] u_data;
  logic [NC-1:0]    u_dvalid;
  logic [NC*CW-1:0] u_crc;
  logic [NC-1:0]    u_crcv;
  logic [NC-1:0]    u_valid;
  logic             u_beat_vld;
`ifdef LPIF_TXRX_BEAT_CNT_EN
  logic [31:0]      tx_beat_cnt;
  logic [31:0]      rx_beat_cnt;
`endif

  lpif_txrx_asym_gearbox dut (
    .clk_wr                 (clk),
    .rst_wr_n               (rst_n),
    .m_gen2_mode            (gen2),
    .dstrm_state            (d_state),
    .dstrm_protid           (d_protid),
    .dstrm_data             (d_data),
    .dstrm_dvalid           (d_dvalid),
    .dstrm_crc              (d_crc),
    .dstrm_crc_valid        (d_crcv),
    .dstrm_valid            (d_valid),
    .dstrm_beat_vld         (d_beat_vld),
    .dstrm_beat_rdy         (dstrm_beat_rdy),
    .txfifo_downstream_data (tx_data),
    .txfifo_vld             (tx_vld),
    .txfifo_rdy             (tx_rdy),
    .rxfifo_upstream_data   (rx_data),
    .rxfifo_vld             (rx_vld),
    .ustrm_state            (u_state),
    .ustrm_protid           (u_protid),
    .ustrm_data             (u_data),
    .ustrm_dvalid           (u_dvalid),
    .ustrm_crc              (u_crc),
    .ustrm_crc_valid        (u_crcv),
    .ustrm_valid            (u_valid),
    .ustrm_beat_vld         (u_beat_vld)
`ifdef LPIF_TXRX_BEAT_CNT_EN
    ,
    .tx_beat_cnt            (tx_beat_cnt),
    .rx_beat_cnt            (rx_beat_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // Link word built from lane fields, LSB first: state, protid, data, dvalid, crc, crc_valid, valid
  function automatic logic [WW-1:0] pack(input logic [NC*SW-1:0] st, input logic [NC*PW-1:0] pr,
                                         input logic [NC*DW-1:0] da, input logic [NC-1:0] dv,
                                         input logic [NC*CW-1:0] cr, input logic [NC-1:0] cv,
                                         input logic [NC-1:0] va);
    logic [WW-1:0] w;
    int o;
    w = '0;
    for (int k = 0; k < NC; k++) begin
      o = k * LW;
      w[o +: SW] = st[k*SW +: SW]; o += SW;
      w[o +: PW] = pr[k*PW +: PW]; o += PW;
      w[o +: DW] = da[k*DW +: DW]; o += DW;
      w[o]       = dv[k];          o += 1;
      w[o +: CW] = cr[k*CW +: CW]; o += CW;
      w[o]       = cv[k];          o += 1;
      w[o]       = va[k];
    end
    return w;
  endfunction

  function automatic logic [WW-1:0] pack_cur();
    return pack(d_state, d_protid, d_data, d_dvalid, d_crc, d_crcv, d_valid);
  endfunction

  function automatic logic [WW-1:0] pack_us();
    return pack(u_state, u_protid, u_data, u_dvalid, u_crc, u_crcv, u_valid);
  endfunction

  // ---------------- reference model ----------------
  logic [WW-1:0] txq[$];
  logic          mmode = 1'b1;
  logic          have_lo = 1'b0;
  logic [HW-1:0] lo_half = '0;
  logic          rx_pend = 1'b0;
  logic [WW-1:0] rx_exp = '0;
  logic [WW-1:0] last_rx = '0;
  logic          rst_prev = 1'b0;
  int            tx_beats = 0;
  int            rx_beats = 0;

  // Expected link stream: pending words queued at each accepted beat, popped on handshake
  always @(negedge clk) begin
    logic          boundary;
    logic          exp_rdy;
    logic [WW-1:0] w;
    if (!rst_n) begin
      if (!rst_prev) begin
        chk("rst_rdy", dstrm_beat_rdy, 0);
        chk("rst_txvld", tx_vld, 0);
        chk("rst_txdata", tx_data, 0);
        chk("rst_pulse", u_beat_vld, 0);
        chk("rst_ustrm", pack_us(), 0);
      end
      txq.delete();
      mmode = 1'b1;
      have_lo = 1'b0;
      rx_pend = 1'b0;
      last_rx = '0;
      tx_beats = 0;
      rx_beats = 0;
      rst_prev = 1'b0;
    end else begin
      boundary = (txq.size() == 0) && !have_lo;
      exp_rdy = (txq.size() == 0) || ((txq.size() == 1) && tx_rdy);
      chk("tx_rdy", dstrm_beat_rdy, exp_rdy);
      chk("tx_vld", tx_vld, txq.size() > 0);
      if (txq.size() > 0) chk("tx_word", tx_data, txq[0]);
      if (tx_vld && tx_rdy && txq.size() > 0) void'(txq.pop_front());
      if (d_beat_vld && exp_rdy) begin
        w = pack_cur();
        tx_beats++;
        if (mmode) txq.push_back(w);
        else begin
          txq.push_back({{(WW-HW){1'b0}}, w[HW-1:0]});
          txq.push_back({{(WW-HW){1'b0}}, w[WW-1 -: HW]});
        end
      end
      chk("rx_pulse", u_beat_vld, rx_pend);
      if (rx_pend) begin
        chk("rx_beat", pack_us(), rx_exp);
        last_rx = rx_exp;
        rx_beats++;
      end else begin
        chk("rx_hold", pack_us(), last_rx);
      end
      rx_pend = 1'b0;
      if (rx_vld) begin
        if (mmode) begin
          rx_pend = 1'b1;
          rx_exp = rx_data;
        end else if (!have_lo) begin
          have_lo = 1'b1;
          lo_half = rx_data[HW-1:0];
        end else begin
          have_lo = 1'b0;
          rx_pend = 1'b1;
          rx_exp = {rx_data[HW-1:0], lo_half};
        end
      end
      if (boundary) mmode = gen2;
      rst_prev = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    d_beat_vld = 1'b0;
    rx_vld = 1'b0;
    tx_rdy = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_lanes(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [63:0] d);
    d_data = {d, c, b, a};
    d_state = 16'h4321;
    d_protid = 8'h1B;
    d_dvalid = 4'hF;
    d_crc = 16'h9A5C;
    d_crcv = 4'h5;
    d_valid = 4'hF;
  endtask

  task automatic rand_beat();
    logic [31:0] t;
    for (int k = 0; k < NC; k++) d_data[k*DW +: DW] = {$urandom(), $urandom()};
    t = $urandom(); d_state = t[NC*SW-1:0];
    t = $urandom(); d_protid = t[NC*PW-1:0];
    t = $urandom(); d_crc = t[NC*CW-1:0];
    t = $urandom(); d_dvalid = t[3:0]; d_crcv = t[7:4]; d_valid = t[11:8];
  endtask

  task automatic rand_rx();
    logic [319:0] t;
    for (int j = 0; j < 10; j++) t[j*32 +: 32] = $urandom();
    rx_data = t[WW-1:0];
  endtask

  logic [WW-1:0] cap[4];
  int            cap_n;

  task automatic capture(input int cyc);
    cap_n = 0;
    for (int c = 0; c < cyc; c++) begin
      @(negedge clk);
      if (tx_vld && tx_rdy && cap_n < 4) begin
        cap[cap_n] = tx_data;
        cap_n++;
      end
      tick();
    end
  endtask

  typedef struct {
    logic        g2;
    logic [63:0] d0, d1, d2, d3;
    int          n;
    logic [63:0] s0w0, s1w0, s3w0, s0w1, s1w1;
  } vec_t;

  vec_t tbl[4];

  task automatic run_random(input logic mode, input int cycles);
    gen2 = mode;
    idle(4);
    for (int i = 0; i < cycles; i++) begin
      rand_beat();
      rand_rx();
      d_beat_vld = ($urandom_range(0, 3) != 0);
      tx_rdy = ($urandom_range(0, 3) != 0);
      rx_vld = ($urandom_range(0, 2) == 0);
      tick();
    end
    d_beat_vld = 1'b0;
    rx_vld = 1'b0;
    tx_rdy = 1'b1;
    tick();
    if (have_lo) begin
      rand_rx();
      rx_vld = 1'b1;
      tick();
      rx_vld = 1'b0;
    end
    idle(6);
  endtask

  initial begin
    logic [WW-1:0] exp_a;
    logic [WW-1:0] exp_b;
    logic [WW-1:0] rw;

    tbl[0] = '{1'b1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333,
               64'h4444_4444_4444_4444, 1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h4444_4444_4444_4444, 64'h0, 64'h0};
    tbl[1] = '{1'b1, 64'hAAAA_5555_AAAA_5555, 64'h0, 64'hDEAD_BEEF_0000_0001,
               64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hAAAA_5555_AAAA_5555, 64'h0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
    tbl[2] = '{1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hDDDD_DDDD_DDDD_DDDD, 2, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
               64'h0, 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    tbl[3] = '{1'b0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
               64'h7E7E_7E7E_7E7E_7E7E, 2, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0, 64'h8000_0000_0000_0001, 64'h7E7E_7E7E_7E7E_7E7E};

    rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", dstrm_beat_rdy, 1);
    tick();

    // Table of single beats in both modes
    for (int v = 0; v < 4; v++) begin
      gen2 = tbl[v].g2;
      idle(4);
      set_lanes(tbl[v].d0, tbl[v].d1, tbl[v].d2, tbl[v].d3);
      d_beat_vld = 1'b1;
      tick();
      d_beat_vld = 1'b0;
      capture(4);
      chk($sformatf("vec%0d_nwords", v), cap_n, tbl[v].n);
      chk($sformatf("vec%0d_w0_s0", v), cap[0][6 +: 64], tbl[v].s0w0);
      chk($sformatf("vec%0d_w0_s1", v), cap[0][LW+6 +: 64], tbl[v].s1w0);
      chk($sformatf("vec%0d_w0_s3", v), cap[0][3*LW+6 +: 64], tbl[v].s3w0);
      if (tbl[v].n == 2) begin
        chk($sformatf("vec%0d_w1_s0", v), cap[1][6 +: 64], tbl[v].s0w1);
        chk($sformatf("vec%0d_w1_s1", v), cap[1][LW+6 +: 64], tbl[v].s1w1);
        chk($sformatf("vec%0d_w0_upper0", v), cap[0][154 +: 154], 0);
        chk($sformatf("vec%0d_w1_upper0", v), cap[1][154 +: 154], 0);
      end
    end

    // Gen2 burst of four beats: four consecutive words, no bubbles
    gen2 = 1'b1;
    idle(4);
    for (int i = 0; i < 7; i++) begin
      d_beat_vld = (i < 4);
      set_lanes(64'(i), 64'(i + 16), 64'(i + 32), 64'(i + 48));
      @(negedge clk);
      if (i >= 1) chk($sformatf("burst_vld%0d", i), tx_vld, (i <= 4));
      tick();
    end
    d_beat_vld = 1'b0;

    // Backpressure in FULL, then release with a back-to-back beat
    idle(4);
    tx_rdy = 1'b0;
    set_lanes(64'hA1, 64'hA2, 64'hA3, 64'hA4);
    exp_a = pack_cur();
    d_beat_vld = 1'b1;
    tick();
    set_lanes(64'hB1, 64'hB2, 64'hB3, 64'hB4);
    exp_b = pack_cur();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_word", tx_data, exp_a);
      chk("bp_rdy", dstrm_beat_rdy, 0);
      tick();
    end
    tx_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", dstrm_beat_rdy, 1);
    tick();
    d_beat_vld = 1'b0;
    @(negedge clk);
    chk("bp_next_word", tx_data, exp_b);
    idle(4);

    // RX Gen1: two halves three cycles apart
    gen2 = 1'b0;
    idle(4);
    rw = pack(16'h0, 8'h0, {64'h9999, 64'h8888, 64'hB0B0_B0B0, 64'hA0A0_A0A0}, 4'hF, 16'h0, 4'h0, 4'hF);
    rx_data = rw;
    rx_vld = 1'b1;
    tick();
    rx_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rx_gap_nopulse", u_beat_vld, 0);
      tick();
    end
    rw = pack(16'h0, 8'h0, {64'h7777, 64'h6666, 64'hD0D0_D0D0, 64'hC0C0_C0C0}, 4'hF, 16'h0, 4'h0, 4'hF);
    rx_data = rw;
    rx_vld = 1'b1;
    tick();
    rx_vld = 1'b0;
    @(negedge clk);
    chk("rx_gen1_pulse", u_beat_vld, 1);
    chk("rx_gen1_data", u_data, {64'hD0D0_D0D0, 64'hC0C0_C0C0, 64'hB0B0_B0B0, 64'hA0A0_A0A0});
    tick();

    // Mode switch 0->1 during HALF_LO: current beat stays two words, next is one
    idle(4);
    tx_rdy = 1'b0;
    set_lanes(64'h51, 64'h52, 64'h53, 64'h54);
    d_beat_vld = 1'b1;
    tick();
    d_beat_vld = 1'b0;
    gen2 = 1'b1;
    tick();
    tx_rdy = 1'b1;
    capture(4);
    chk("modesw_first_nwords", cap_n, 2);
    idle(3);
    set_lanes(64'h61, 64'h62, 64'h63, 64'h64);
    d_beat_vld = 1'b1;
    tick();
    d_beat_vld = 1'b0;
    capture(4);
    chk("modesw_second_nwords", cap_n, 1);
    chk("modesw_second_s3", cap[0][3*LW+6 +: 64], 64'h64);

    // Randomized traffic in both modes
    run_random(1'b1, 400);
    run_random(1'b0, 400);
    run_random(1'b1, 200);
`ifdef LPIF_TXRX_BEAT_CNT_EN
    chk("tx_cnt", tx_beat_cnt, tx_beats);
    chk("rx_cnt", rx_beat_cnt, rx_beats);
`endif

    // Reset while TX is in HALF_LO and RX holds a first half
    gen2 = 1'b0;
    idle(4);
    tx_rdy = 1'b0;
    set_lanes(64'h71, 64'h72, 64'h73, 64'h74);
    d_beat_vld = 1'b1;
    rand_rx();
    rx_vld = 1'b1;
    tick();
    d_beat_vld = 1'b0;
    rx_vld = 1'b0;
    tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tx_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_txvld", tx_vld, 0);
      chk("postrst_pulse", u_beat_vld, 0);
      tick();
    end
`ifdef LPIF_TXRX_BEAT_CNT_EN
    chk("postrst_txcnt", tx_beat_cnt, 0);
    chk("postrst_rxcnt", rx_beat_cnt, 0);
`endif
    rand_rx();
    rx_vld = 1'b1;
    tick();
    rx_vld = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
